// File: rtl/qarma128_tweak_sched_pkg.sv
// qarma128_pkg: shared constants, cell tables, LFSR helpers and state enum for the QARMA-128 tweak schedule
package qarma128_pkg;
  localparam int N = 128;
  localparam int CELL_W = 8;
  localparam int CELLS = N / CELL_W;
  localparam int H [CELLS] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
  localparam int H_INV [CELLS] = '{4, 5, 6, 7, 11, 1, 0, 8, 12, 13, 14, 15, 9, 10, 2, 3};
  // bit i selects cell i; cells 0,1,3,4,8,11,13
  localparam logic [CELLS-1:0] LFSR_MASK = 16'h291B;
  typedef enum logic [1:0] {IDLE, FWD, BWD} state_e;
  function automatic logic [CELL_W-1:0] lfsr_fwd(input logic [CELL_W-1:0] b);
    return {b[0] ^ b[2], b[7:1]};
  endfunction
  function automatic logic [CELL_W-1:0] lfsr_inv(input logic [CELL_W-1:0] y);
    return {y[6:0], y[7] ^ y[1]};
  endfunction
endpackage

// File: rtl/qarma128_tweak_sched_if.sv
// qarma128_tweak_sched_if: load request and round-tweak stream between scheduler and round datapath
interface qarma128_tweak_sched_if
  import qarma128_pkg::*;
#(parameter int ROUNDS = 8);
  localparam int RW = $clog2(2 * ROUNDS);
  logic          start_i;
  logic [N-1:0]  tweak_i;
  logic          busy_o;
  logic          tk_valid_o;
  logic          tk_ready_i;
  logic [N-1:0]  tk_o;
  logic [RW-1:0] round_o;
  logic          dir_o;
  logic          done_o;
  logic          err_o;
  modport master (
    output start_i, tweak_i, tk_ready_i,
    input  busy_o, tk_valid_o, tk_o, round_o, dir_o, done_o, err_o
  );
  modport slave (
    input  start_i, tweak_i, tk_ready_i,
    output busy_o, tk_valid_o, tk_o, round_o, dir_o, done_o, err_o
  );
endinterface

// File: rtl/qarma128_tweak_step.sv
// qarma128_tweak_step: one tweak update, forward (shuffle then LFSR) or inverse (LFSR^-1 then shuffle^-1)
module qarma128_tweak_step
  import qarma128_pkg::*;
(
  input  logic         dir_i,
  input  logic [N-1:0] tk_i,
  output logic [N-1:0] tk_o
);
  logic [N-1:0] shuf, fwd, unl, bwd;
  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign shuf[N-1-CELL_W*i -: CELL_W] = tk_i[N-1-CELL_W*H[i] -: CELL_W];
    assign fwd[N-1-CELL_W*i -: CELL_W]  = LFSR_MASK[i] ? lfsr_fwd(shuf[N-1-CELL_W*i -: CELL_W])
                                                       : shuf[N-1-CELL_W*i -: CELL_W];
    assign unl[N-1-CELL_W*i -: CELL_W]  = LFSR_MASK[i] ? lfsr_inv(tk_i[N-1-CELL_W*i -: CELL_W])
                                                       : tk_i[N-1-CELL_W*i -: CELL_W];
    assign bwd[N-1-CELL_W*i -: CELL_W]  = unl[N-1-CELL_W*H_INV[i] -: CELL_W];
  end
  assign tk_o = dir_i ? bwd : fwd;
endmodule

// File: rtl/qarma128_tweak_sched.sv
// qarma128_tweak_sched: iterative QARMA-128 tweak scheduler, forward then exact reverse walk.
// Optional self-check of the reversal against a T0 shadow under QARMA_TWEAK_CHECK_EN.
module qarma128_tweak_sched
  import qarma128_pkg::*;
#(parameter int ROUNDS = 8)
(
  input  logic clk,
  input  logic rst,
  qarma128_tweak_sched_if.slave bus
);
  localparam int RW = $clog2(2 * ROUNDS);
  localparam logic [RW-1:0] MID  = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] LAST = RW'(2 * ROUNDS - 1);
  state_e        state_q, state_d;
  logic [N-1:0]  tk_q, tk_d, step;
  logic [RW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          hs, last_hs, load;
  assign load    = state_q == IDLE && bus.start_i;
  assign hs      = state_q != IDLE && bus.tk_ready_i;
  assign last_hs = hs && state_q == BWD && idx_q == LAST;
  qarma128_tweak_step u_step (.dir_i(state_q == BWD), .tk_i(tk_q), .tk_o(step));
  always_comb begin
    state_d = state_q;
    tk_d    = tk_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = FWD;
        tk_d    = bus.tweak_i;
        idx_d   = '0;
      end
      // the midpoint handshake only advances the index so T_{R-1} is emitted twice
      FWD: if (hs) begin
        idx_d   = idx_q + 1'b1;
        tk_d    = idx_q == MID ? tk_q : step;
        state_d = idx_q == MID ? BWD : FWD;
      end
      BWD: if (hs) begin
        idx_d   = last_hs ? idx_q : idx_q + 1'b1;
        tk_d    = last_hs ? tk_q : step;
        state_d = last_hs ? IDLE : BWD;
        done_d  = last_hs;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tk_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tk_q    <= tk_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy_o     = state_q != IDLE;
  assign bus.tk_valid_o = state_q != IDLE;
  assign bus.tk_o       = tk_q;
  assign bus.round_o    = idx_q;
  assign bus.dir_o      = state_q == BWD;
  assign bus.done_o     = done_q;
`ifdef QARMA_TWEAK_CHECK_EN
  logic [N-1:0] sh_q;
  logic         err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      err_q <= 1'b0;
    end else if (load) begin
      sh_q  <= bus.tweak_i;
      err_q <= 1'b0;
    end else if (last_hs && tk_q != sh_q) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_qarma128_tweak_sched.sv
// tb_qarma128_tweak_sched: randomized scoreboard bench against a software model of the tweak schedule
module tb_qarma128_tweak_sched;
  localparam int R = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  qarma128_tweak_sched_if #(.ROUNDS(R)) bus();
  qarma128_tweak_sched #(.ROUNDS(R)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct packed {
    logic [127:0] tk;
    logic [3:0]   rnd;
    logic         dir;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int rmode = 0;
  logic err_exp = 1'b0;
  logic tk_chk = 1'b1;
  logic done_exp = 1'b0;
  logic stall_p = 1'b0;
  logic [127:0] p_tk, r1_tk;
  logic [3:0] p_rnd;
  logic p_dir;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] fwd_step(input logic [127:0] t);
    int h [16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
    int lc [7] = '{0, 1, 3, 4, 8, 11, 13};
    int c [16];
    int s [16];
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) c[i] = int'(t[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) s[i] = c[h[i]];
    for (int k = 0; k < 7; k++) s[lc[k]] = (s[lc[k]] >> 1) | (((s[lc[k]] ^ (s[lc[k]] >> 2)) & 1) << 7);
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = 8'(s[i]);
    return r;
  endfunction

  task automatic push_sched(input logic [127:0] t0);
    logic [127:0] t [R];
    exp_t e;
    t[0] = t0;
    for (int i = 1; i < R; i++) t[i] = fwd_step(t[i-1]);
    for (int i = 0; i < 2 * R; i++) begin
      if (i < R) e.tk = t[i];
      else e.tk = t[2*R-1-i];
      e.rnd = 4'(i);
      e.dir = i >= R;
      q.push_back(e);
    end
  endtask

  initial forever begin
    bus.tk_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk);
    #1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_p  = 1'b0;
      done_exp = 1'b0;
    end else begin
      if (done_exp) begin
        chk("done_pulse", 128'(bus.done_o), 128'(1));
        chk("done_busy", 128'(bus.busy_o), 128'(0));
        chk("done_valid", 128'(bus.tk_valid_o), 128'(0));
        chk("done_err", 128'(bus.err_o), 128'(err_exp));
      end else if (bus.done_o) begin
        chk("done_spurious", 128'(bus.done_o), 128'(0));
      end
      done_exp = 1'b0;
      if (stall_p && bus.tk_valid_o) begin
        if (tk_chk) chk("hold_tk", bus.tk_o, p_tk);
        chk("hold_round", 128'(bus.round_o), 128'(p_rnd));
        chk("hold_dir", 128'(bus.dir_o), 128'(p_dir));
      end
      if (bus.tk_valid_o && bus.tk_ready_i) begin
        if (q.size() == 0) begin
          chk("unexpected_tweak", 128'(bus.tk_valid_o), 128'(0));
        end else begin
          e = q.pop_front();
          if (tk_chk) chk("tk", bus.tk_o, e.tk);
          chk("round", 128'(bus.round_o), 128'(e.rnd));
          chk("dir", 128'(bus.dir_o), 128'(e.dir));
          if (bus.round_o == 4'd1) r1_tk = bus.tk_o;
          if (e.rnd == 4'(2 * R - 1)) done_exp = 1'b1;
        end
      end
      stall_p = bus.tk_valid_o && !bus.tk_ready_i;
      p_tk  = bus.tk_o;
      p_rnd = bus.round_o;
      p_dir = bus.dir_o;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 128'(bus.busy_o), 128'(0));
    chk({tag, "_valid"}, 128'(bus.tk_valid_o), 128'(0));
    chk({tag, "_tk"}, bus.tk_o, 128'(0));
    chk({tag, "_round"}, 128'(bus.round_o), 128'(0));
    chk({tag, "_dir"}, 128'(bus.dir_o), 128'(0));
    chk({tag, "_done"}, 128'(bus.done_o), 128'(0));
    chk({tag, "_err"}, 128'(bus.err_o), 128'(0));
  endtask

  task automatic kick(input logic [127:0] t0);
    push_sched(t0);
    @(posedge clk);
    #1;
    bus.tweak_i = t0;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done_o && n < 2000);
    chk("done_seen", 128'(bus.done_o), 128'(1));
    if (exp_n > 0) chk("done_latency", 128'(n), 128'(exp_n));
    chk("queue_drained", 128'(q.size()), 128'(0));
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.tk_valid_o && bus.round_o == 4'(r)) && n < 2000);
    chk("reach_round", 128'(bus.round_o), 128'(r));
  endtask

  task automatic run(input logic [127:0] t0, input int mode, input int exp_n);
    rmode = mode;
    kick(t0);
    wait_done(exp_n);
  endtask

  initial begin
    logic [127:0] t, v;
    bus.start_i = 1'b0;
    bus.tweak_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    run('0, 0, 2 * R + 1);
    t = 128'h01 << 120;
    run(t, 0, 2 * R + 1);
    chk("round1_fixed", r1_tk, 128'h00000000_80000000_00000000_00000000);
    repeat (4) run({$urandom, $urandom, $urandom, $urandom}, 0, 2 * R + 1);
    repeat (4) run({$urandom, $urandom, $urandom, $urandom}, 1, 0);
    rmode = 0;
    kick({$urandom, $urandom, $urandom, $urandom});
    repeat (2) @(posedge clk);
    #1;
    bus.tweak_i = {$urandom, $urandom, $urandom, $urandom};
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    wait_round(10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run({$urandom, $urandom, $urandom, $urandom}, 0, 2 * R + 1);
    run({$urandom, $urandom, $urandom, $urandom}, 1, 0);
`ifdef QARMA_TWEAK_CHECK_EN
    rmode = 0;
    kick({$urandom, $urandom, $urandom, $urandom});
    wait_round(10);
    @(posedge clk);
    #1;
    tk_chk = 1'b0;
    v = dut.tk_q ^ 128'h1;
    force dut.tk_q = v;
    @(negedge clk);
    release dut.tk_q;
    err_exp = 1'b1;
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 128'(bus.err_o), 128'(1));
    tk_chk = 1'b1;
    err_exp = 1'b0;
    kick({$urandom, $urandom, $urandom, $urandom});
    chk("err_cleared", 128'(bus.err_o), 128'(0));
    wait_done(0);
`endif
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qarma128_tweak_sched.md
# qarma128_tweak_sched

Iterative QARMA-128 tweak scheduler: captures a 128-bit tweak, then streams the round tweaks for the forward half of the cipher by applying the tweak update (cell shuffle, then LFSR). For the backward half it walks the same sequence in reverse by applying the inverse update (inverse LFSR, then inverse shuffle). It sits beside the iterative round datapath and feeds it one round tweak per accepted handshake. The backward half needs no stored copies of the forward tweaks.

## Interface
- `ROUNDS`, 8: forward rounds R; the schedule emits 2R tweaks.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  load request; sampled only in IDLE.
- `tweak_i`  in  128  initial tweak T0; captured with `start_i`.
- `busy_o`  out  1  schedule in progress.
- `tk_valid_o`  out  1  `tk_o` holds a valid round tweak.
- `tk_ready_i`  in  1  consumer accepts `tk_o`.
- `tk_o`  out  128  current round tweak.
- `round_o`  out  $clog2(2R)  index of `tk_o`, 0..2R-1.
- `dir_o`  out  1  0 = forward half, 1 = backward half.
- `done_o`  out  1  one-cycle pulse after the last tweak is accepted.
- `err_o`  out  1  schedule self-check failure (see Configuration).

## Operation
- Cell layout: 16 cells of 8 bits; cell 0 is `tk[127:120]`, cell 15 is `tk[7:0]`.
- Shuffle h: new cell i = old cell h[i], with h = 6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11. The inverse shuffle uses h⁻¹.
- LFSR applies to cells 0,1,3,4,8,11,13 only.
  - Forward, per 8-bit cell: y = {b0^b2, b[7:1]}.
  - Inverse: b = {y[6:0], y[7]^y[1]}.
- Forward step: T_{i+1} = LFSR(shuffle(T_i)).
- Inverse step: T_i = shuffle⁻¹(LFSR⁻¹(T_{i+1})).
- Emitted sequence: T0, T1, …, T_{R-1}, then T_{R-1}, …, T0. `round_o` runs 0..2R-1.
- States:
  - IDLE: `start_i` loads `tweak_i` into the tweak register and clears the index; go to FWD.
  - FWD: on each handshake (`tk_valid_o & tk_ready_i`):
    - at index < R-1: apply the forward step and increment the index.
    - at index = R-1: increment the index without updating the register, so T_{R-1} repeats; go to BWD.
  - BWD: on each handshake:
    - at index < 2R-1: apply the inverse step and increment the index.
    - at index = 2R-1: go to IDLE and pulse `done_o`.
- Without a handshake, the register, index and outputs hold.
- `start_i` in FWD or BWD is ignored.
- Reset, including mid-schedule: state IDLE; register, index, `busy_o`, `tk_valid_o`, `tk_o`, `round_o`, `dir_o`, `done_o` and `err_o` all 0.

## Timing
- `start_i` sampled high in IDLE at cycle k: `busy_o`, `tk_valid_o` and T0 on `tk_o` appear at cycle k+1.
- With `tk_ready_i` held high: one tweak per cycle. The last handshake is at cycle k+2R.
- `done_o` is high at cycle k+2R+1. In that same cycle `busy_o` and `tk_valid_o` are 0.
- A new `start_i` is accepted at cycle k+2R+1 at the earliest.
- `tk_valid_o`, `tk_o`, `round_o` and `dir_o` are registered. The step logic is combinational between the register and its D input, so there is no added latency.
- `tk_o` is stable while `tk_valid_o & !tk_ready_i`.

## Configuration
- `QARMA_TWEAK_CHECK_EN` defined:
  - T0 is kept in a shadow register.
  - On the final BWD handshake, the register is compared with the shadow. On mismatch, `err_o` is set.
  - `err_o` is sticky until the next accepted `start_i` or `rst`.
- `QARMA_TWEAK_CHECK_EN` undefined: no shadow register and `err_o` is tied to 0.

## Structure
- `qarma128_pkg` holds:
  - N = 128 and CELL_W = 8;
  - the h and h⁻¹ cell-index constant arrays;
  - the LFSR cell mask (cells 0,1,3,4,8,11,13);
  - the state enum (IDLE, FWD, BWD).
- One sub-module, `qarma128_tweak_step`: a combinational 128→128 block with a `dir` input (0 = forward step, 1 = inverse step). The scheduler instantiates it once and drives `dir` from the state.

## Test plan
- `tweak_i` = 0, ready always high → 16 tweaks, all 0; `round_o` 0..15; `dir_o` is 0 for rounds 0–7 and 1 for rounds 8–15; `done_o` at k+17.
- `tweak_i` with cell 0 = 0x01, all other cells 0 → round 1 `tk_o` = 128'h00000000_80000000_00000000_00000000; round 15 `tk_o` equals `tweak_i`.
- Random `tweak_i` compared against a software model of T0..T7 → both halves match and the reversal is exact; `round_o` 7 and 8 show identical `tk_o`.
- Random `tk_ready_i` backpressure → `tk_o`, `round_o` and `dir_o` hold while stalled; sequence identical to the no-stall run.
- `start_i` pulsed during FWD, and `rst` asserted at round 10 → start ignored; after reset all outputs are 0; a fresh start produces a correct full schedule.
- With `QARMA_TWEAK_CHECK_EN`: force-flip one register bit mid-BWD → `err_o` = 1 after the final handshake, and it clears on the next `start_i`.
